// File: rtl/ym3014_rx_pkg.sv
// Shared YM3014 frame layout, used by the receiver and the DAC driver model.
// Field positions, frame width and the mute exponent live here.
package ym3014_rx_pkg;

   localparam int FRAME_W = 16;
   localparam int CNT_W   = 5;

   localparam logic [CNT_W-1:0] FRAME_CNT = 5'd16;
   localparam logic [CNT_W-1:0] CNT_MAX   = 5'd31;
   localparam logic [2:0]       MUTE_EXP  = 3'd0;

   typedef struct packed {
      logic [2:0] exp;
      logic [9:0] mant;
   } frame_t;

   // sr[15:13] = S2..S0, sr[12:3] = D9..D0, sr[2:0] unused
   function automatic frame_t getFrame(input logic [FRAME_W-1:0] sr);
      frame_t f;
      f.exp  = sr[15:13];
      f.mant = sr[12:3];
      return f;
   endfunction

endpackage

// File: rtl/ym3014_decode.sv
// YM3014 floating point to signed 16-bit linear PCM.
// Purely combinational; shared with the transmit-side model.
module ym3014_decode
   import ym3014_rx_pkg::*;
(
   input  frame_t      iFrame,
   output logic [15:0] oSample
);

   logic [15:0] s16;

   always_comb begin
      s16 = {{6{~iFrame.mant[9]}}, ~iFrame.mant[9], iFrame.mant[8:0]};
      if (iFrame.exp == MUTE_EXP) begin
         oSample = 16'h0000;
      end else begin
         oSample = s16 << (iFrame.exp - 3'd1);
      end
   end

endmodule

// File: rtl/ym3014_rx.sv
// YM3014 serial DAC link receiver: sync, edge detect, shift/count, decode.
// Define YM3014_RX_FIFO_EN to buffer samples in a FIFO_DEPTH FIFO.
module ym3014_rx
   import ym3014_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iDacClk,
   input  logic        iDacSd,
   input  logic        iDacLoad,
   input  logic        iReady,
   output logic [15:0] oSample,
   output logic        oValid,
   output logic        oErr,
   output logic        oOvf
);

   logic [2:0] raw;
   logic [2:0] syn;
   logic [2:0] prev;

   assign raw = {iDacLoad, iDacSd, iDacClk};

   generate
      if (SYNC_STAGES == 0) begin : gNoSync
         assign syn = raw;
      end else begin : gSync
         logic [2:0] stg [SYNC_STAGES];
         always_ff @(posedge iClk) begin
            stg[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               stg[i] <= stg[i-1];
            end
         end
         assign syn = stg[SYNC_STAGES-1];
      end
   endgenerate

   logic             clkRise;
   logic             loadFall;
   logic [15:0]      sr;
   logic [15:0]      srNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;
   logic             frameOk;
   logic             frameBad;
   frame_t           frame;
   logic [15:0]      decoded;

   assign clkRise  = syn[0] & ~prev[0];
   assign loadFall = ~syn[2] & prev[2];

   // A bit arriving with the load fall belongs to the closing frame
   always_comb begin
      srNext  = sr;
      cntNext = cnt;
      if (clkRise) begin
         srNext = {syn[1], sr[15:1]};
         if (cnt != CNT_MAX) cntNext = cnt + 1'b1;
      end
   end

   assign frameOk  = loadFall & (cntNext == FRAME_CNT);
   assign frameBad = loadFall & (cntNext != FRAME_CNT);
   assign frame    = getFrame(srNext);

   ym3014_decode uDecode (
      .iFrame  (frame),
      .oSample (decoded)
   );

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         sr   <= '0;
         cnt  <= '0;
         prev <= syn;
         oErr <= 1'b0;
      end else begin
         prev <= syn;
         oErr <= frameBad;
         if (loadFall) begin
            sr  <= '0;
            cnt <= '0;
         end else begin
            sr  <= srNext;
            cnt <= cntNext;
         end
      end
   end

`ifdef YM3014_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [15:0] mem [FIFO_DEPTH];
   logic [AW:0] wp;
   logic [AW:0] rp;
   logic        full;
   logic        empty;
   logic        pop;
   logic        push;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop   = ~empty & iReady;
   assign push  = frameOk & (~full | pop);

   always_ff @(posedge iClk) begin
      if (push) mem[wp[AW-1:0]] <= decoded;
   end

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         wp   <= '0;
         rp   <= '0;
         oOvf <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         if (frameOk && full && !pop) oOvf <= 1'b1;
      end
   end

   assign oValid  = ~empty;
   assign oSample = mem[rp[AW-1:0]];
`else
   logic unusedReady;
   assign unusedReady = iReady;
   assign oOvf        = 1'b0;

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         oValid  <= 1'b0;
         oSample <= 16'h0000;
      end else begin
         oValid <= frameOk;
         if (frameOk) oSample <= decoded;
      end
   end
`endif

endmodule
